imem_program_loader: RTL and testbench

//  Sequential RV32I instruction encoder and program loader, the inverse of the ID decoder.

---
 rtl/imem_program_loader.sv | 137 +++++++++++++
 tb/tb_imem_program_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// RV32I field-bundle encoder that streams packed words into instruction memory
// and holds the core in reset until the program image is complete.
module imem_program_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [2:0]        i_in_kind,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [2:0]        i_in_funct3,
  input  logic [6:0]        i_in_funct7,
  input  logic [12:0]       i_in_imm,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_count, w_count_next;
  logic              r_err, w_err_next;
  logic              r_we, w_we_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [31:0]       r_wdata, w_wdata_next;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_ready;
  logic              w_accept;
  logic [CntW-1:0]   w_count_inc;
  logic              w_unused_imm0;

  // Branch offsets are always even, so bit 0 carries no information.
  assign w_unused_imm0 = i_in_imm[0];

  always_comb begin
    w_word    = Nop;
    w_illegal = 1'b0;
    case (i_in_kind)
      3'd0: w_word = {i_in_funct7, i_in_rs2, i_in_rs1, i_in_funct3, i_in_rd, 7'b0110011};
      3'd1: w_word = {i_in_imm[11:0], i_in_rs1, i_in_funct3, i_in_rd, 7'b0010011};
      3'd2: w_word = {i_in_imm[11:0], i_in_rs1, i_in_funct3, i_in_rd, 7'b0000011};
      3'd3: w_word = {i_in_imm[11:5], i_in_rs2, i_in_rs1, i_in_funct3, i_in_imm[4:0],
                      7'b0100011};
      3'd4: w_word = {i_in_imm[12], i_in_imm[10:5], i_in_rs2, i_in_rs1, i_in_funct3,
                      i_in_imm[4:1], i_in_imm[11], 7'b1100011};
      3'd5: w_word = {i_in_imm[11:0], i_in_rs1, 3'b000, i_in_rd, 7'b1100111};
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_ready     = (r_state == StLoad) && (r_count < CntW'(DEPTH));
  assign w_accept    = i_in_valid && w_ready;
  assign w_count_inc = r_count + CntW'(1);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_err_next   = r_err;
    w_we_next    = 1'b0;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_next = StLoad;
          w_count_next = '0;
          w_err_next   = 1'b0;
        end
      end
      StLoad: begin
        if (w_accept) begin
          w_we_next    = 1'b1;
          w_addr_next  = r_count[ADDR_W-1:0];
          w_wdata_next = w_word;
          w_count_next = w_count_inc;
          if (w_illegal) w_err_next = 1'b1;
          if (i_in_last) begin
            w_state_next = StFlush;
          end else if (w_count_inc == CntW'(DEPTH)) begin
            // Image did not fit: stop before the address could wrap.
            w_state_next = StFlush;
            w_err_next   = 1'b1;
          end
        end
      end
      StFlush: w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= StIdle;
      r_count <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_err   <= w_err_next;
      r_we    <= w_we_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
    end
  end

  assign o_in_ready   = w_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_busy       = (r_state == StLoad) || (r_state == StFlush);
  assign o_done       = (r_state == StDone);
  // A restart pulls the core back into reset in the same cycle start is seen.
  assign o_core_rst_n = (r_state == StDone) && !i_start;
  assign o_err        = r_err;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: directed encodings plus randomized streams checked
// every cycle against a transaction-level model of the loader.
module tb_imem_program_loader;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_last;
  logic [2:0]        in_kind, in_funct3;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [6:0]        in_funct7;
  logic [12:0]       in_imm;
  logic              in_ready, imem_we, core_rst_n, busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 accepting, 2 final write, 3 image ready.
  int          m_phase, m_count, m_addr;
  bit          m_err, m_we, m_after_rst;
  logic [31:0] m_wdata;

  imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_last(in_last), .i_in_kind(in_kind), .i_in_rd(in_rd), .i_in_rs1(in_rs1),
    .i_in_rs2(in_rs2), .i_in_funct3(in_funct3), .i_in_funct7(in_funct7), .i_in_imm(in_imm),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_core_rst_n(core_rst_n), .o_busy(busy), .o_done(done), .o_err(err),
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_enc(input int unsigned k, rd, rs1, rs2, f3, f7, imm);
    int unsigned i12 = imm & 32'hFFF;
    int unsigned w;
    case (k)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: w = (i12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2: w = (i12 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      3: w = ((i12 >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((i12 & 31) << 7) | 32'h23;
      4: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
             | (((imm >> 11) & 1) << 7) | 32'h63;
      5: w = (i12 << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      default: w = 32'h13;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    m_after_rst = !rst;
    if (!rst) begin
      m_phase = 0; m_count = 0; m_err = 0; m_we = 0; m_addr = 0; m_wdata = '0;
      return;
    end
    acc  = in_valid && m_phase == 1 && m_count < DEPTH;
    m_we = acc;
    case (m_phase)
      0, 3: if (start) begin m_phase = 1; m_count = 0; m_err = 0; end
      1: if (acc) begin
        m_addr  = m_count;
        m_wdata = ref_enc(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        if (in_kind > 5) m_err = 1;
        m_count++;
        if (in_last) m_phase = 2;
        else if (m_count == DEPTH) begin m_phase = 2; m_err = 1; end
      end
      default: m_phase = 3;
    endcase
  endtask

  task automatic compare_all();
    chk("imem_we", imem_we, m_we);
    if (m_we || m_after_rst) begin
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, m_wdata);
    end
    chk("in_ready", in_ready, (m_phase == 1 && m_count < DEPTH));
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("done", done, (m_phase == 3));
    chk("core_rst_n", core_rst_n, (m_phase == 3 && !start));
    chk("err", err, m_err);
    chk("word_count", word_count, m_count);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_fields(input int unsigned k, rd, rs1, rs2, f3, f7, imm);
    in_kind = 3'(k); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = 13'(imm);
  endtask

  task automatic rand_fields(input bit allow_illegal);
    int unsigned k = $urandom_range(0, 5);
    if (allow_illegal && $urandom_range(0, 9) == 0) k = 6 + $urandom_range(0, 1);
    set_fields(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 8191));
  endtask

  task automatic send_lit(input string name, input int unsigned k, rd, rs1, rs2, f3, imm,
                          input bit last, input logic [31:0] lit);
    set_fields(k, rd, rs1, rs2, f3, 0, imm);
    in_valid = 1'b1; in_last = last;
    cycle();
    in_valid = 1'b0; in_last = 1'b0;
    chk({name, " we"}, imem_we, 1);
    chk({name, " wdata"}, imem_wdata, lit);
    chk({name, " model"}, ref_enc(k, rd, rs1, rs2, f3, 0, imm), lit);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    m_phase = 0; m_count = 0; m_err = 0; m_we = 0; m_addr = 0; m_wdata = '0; m_after_rst = 1;
    repeat (2) cycle();
    chk("rst core_rst_n", core_rst_n, 0);
    chk("rst word_count", word_count, 0);
    chk("rst busy", busy, 0);
    rst = 1'b1;
    cycle();

    // Single-instruction image.
    start = 1'b1; cycle(); start = 1'b0;
    send_lit("add", 0, 3, 1, 2, 0, 0, 1'b1, 32'h002081B3);
    chk("add addr", imem_addr, 0);
    repeat (2) cycle();
    chk("add done", done, 1);
    chk("add core_rst_n", core_rst_n, 1);

    // Restart from DONE; core reset drops in the same cycle.
    start = 1'b1; #1;
    chk("restart core_rst_n", core_rst_n, 0);
    cycle(); start = 1'b0;
    send_lit("sw", 3, 0, 1, 2, 2, 8, 1'b0, 32'h0020A423);
    send_lit("beq", 4, 0, 1, 2, 0, 13'h1FF8, 1'b0, 32'hFE208CE3);
    send_lit("illegal", 7, 9, 9, 9, 5, 99, 1'b0, 32'h00000013);
    chk("illegal err", err, 1);
    chk("illegal busy", busy, 1);
    send_lit("jalr", 5, 1, 5, 0, 0, 0, 1'b1, 32'h000280E7);
    chk("jalr addr", imem_addr, 3);
    repeat (2) cycle();
    chk("img4 done", done, 1);
    chk("img4 count", word_count, 4);

    // Overflow: five valid bundles, none marked last.
    start = 1'b1; cycle(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_fields(1'b0); cycle(); end
    in_valid = 1'b0;
    cycle();
    chk("ovf count", word_count, 4);
    chk("ovf err", err, 1);
    chk("ovf done", done, 1);

    // Reset mid-load after two words, then reload one word.
    start = 1'b1; cycle(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin rand_fields(1'b0); cycle(); end
    in_valid = 1'b0; rst = 1'b0;
    cycle();
    chk("midrst we", imem_we, 0);
    chk("midrst busy", busy, 0);
    chk("midrst count", word_count, 0);
    chk("midrst addr", imem_addr, 0);
    rst = 1'b1; cycle();
    start = 1'b1; cycle(); start = 1'b0;
    send_lit("reload", 1, 7, 3, 0, 4, 13'h07F, 1'b1, 32'h07F1C393);
    chk("reload addr", imem_addr, 0);
    repeat (2) cycle();

    // Randomized streams with back-pressure, stray starts and occasional reset.
    for (int r = 0; r < 25; r++) begin
      start = 1'b1; cycle(); start = 1'b0;
      for (int c = 0; c < 30; c++) begin
        rand_fields(1'b1);
        in_valid = $urandom_range(0, 1) == 1;
        in_last  = $urandom_range(0, 5) == 0;
        start    = $urandom_range(0, 7) == 0;
        rst      = $urandom_range(0, 60) != 0;
        cycle();
        if (m_phase == 3) break;
      end
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      repeat (3) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
